// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the multicycle memory access unit.
package mem_access_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } cmd_e;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Saturating wait counter for an outstanding memory access.
module wait_timer
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory access unit: registered strobes, wait/timeout handling,
// instruction register and memory data register capture.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic          IorD,
  input  logic          IR_write,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [AW-1:0] write_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_wdata,
  input  logic [AW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall,
  output logic [AW-1:0] instr,
  output logic [5:0]    opcode,
  output logic [AW-1:0] mdr,
  output logic          err
);

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic          ir_sel_q, ir_sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] instr_q, instr_d;
  logic [AW-1:0] mdr_q, mdr_d;
  logic          err_q, err_d;

  logic          tmr_clear, tmr_enable, tmr_expired;
  logic          stall_c;
  logic [AW-1:0] sel_addr;
  logic          req_any, req_legal;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  assign sel_addr  = IorD ? alu_out : pc;
  assign req_any   = memread | memwrite;
  assign req_legal = (memread ^ memwrite) && is_aligned(sel_addr[1:0]);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    ir_sel_d   = ir_sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    instr_d    = instr_q;
    mdr_d      = mdr_q;
    err_d      = err_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    stall_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_legal) begin
            addr_d    = sel_addr;
            wdata_d   = write_data;
            cmd_d     = memwrite ? WR : RD;
            ir_sel_d  = IR_write;
            rd_d      = memread;
            wr_d      = memwrite;
            tmr_clear = 1'b1;
            stall_c   = 1'b1;
            state_d   = BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        // Ready wins over expiry when both land in the same cycle.
        if (mem_ready) begin
          if (cmd_q == RD) begin
            if (ir_sel_q) begin
              instr_d = mem_rdata;
            end else begin
              mdr_d = mem_rdata;
            end
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else begin
          tmr_enable = 1'b1;
          stall_c    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= RD;
      ir_sel_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      instr_q  <= '0;
      mdr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      ir_sel_q <= ir_sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      instr_q  <= instr_d;
      mdr_q    <= mdr_d;
      err_q    <= err_d;
    end
  end

  // Reset is asynchronous, so the combinational stall must drop with it too.
  assign stall     = stall_c & ~reset;
  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign mdr       = mdr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected accesses,
// a negedge monitor pops them on completion and tracks instr/mdr/err.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite, IorD, IR_write;
  logic [31:0] pc, alu_out, write_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready, stall, err;
  logic [31:0] instr, mdr;
  logic [5:0]  opcode;

  mem_access_unit #(.TIMEOUT(TO), .AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .IorD       (IorD),
    .IR_write   (IR_write),
    .pc         (pc),
    .alu_out    (alu_out),
    .write_data (write_data),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .instr      (instr),
    .opcode     (opcode),
    .mdr        (mdr),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          ir;
  } txn_t;

  txn_t        sb_q[$];
  txn_t        mon_t;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_mdr = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: register state every cycle, access contents on each completion.
  always @(negedge clk) begin
    if (!reset) begin
      chk("instr", instr, exp_instr);
      chk("mdr", mdr, exp_mdr);
      chk("err", err, exp_err);
      chk("opcode", opcode, exp_instr[31:26]);
      chk("strobe_excl", mem_rd & mem_wr, 0);
      if ((mem_rd | mem_wr) && mem_ready) begin
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_t = sb_q.pop_front();
          chk("acc_addr", mem_addr, mon_t.addr);
          chk("acc_wr", mem_wr, mon_t.wr);
          chk("acc_rd", mem_rd, !mon_t.wr);
          if (mon_t.wr) chk("acc_wdata", mem_wdata, mon_t.wdata);
          else if (mon_t.ir) exp_instr = mon_t.rdata;
          else exp_mdr = mon_t.rdata;
        end
      end
    end
  end

  task automatic idle_inputs();
    memread = 0; memwrite = 0; mem_ready = 0;
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      memread = 0; memwrite = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #2;
      chk("idle_stall", stall, 0);
      chk("idle_strobe", {mem_rd, mem_wr}, 2'b00);
      @(posedge clk); #1;
    end
    mem_ready = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic do_access(input bit wr, input bit iord, input bit irw,
                           input logic [31:0] pcv, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int unsigned lat,
                           output int unsigned stall_cyc, output int unsigned strobe_cyc);
    logic [31:0] a;
    a = iord ? alu : pcv;
    memread = !wr; memwrite = wr; IorD = iord; IR_write = irw;
    pc = pcv; alu_out = alu; write_data = wd; mem_ready = 0;
    sb_q.push_back('{wr, a, wd, rd, irw});
    stall_cyc = 0; strobe_cyc = 0;
    #2;
    chk("issue_stall", stall, 1);
    if (stall) stall_cyc++;
    @(posedge clk); #1;
    for (int unsigned i = 0; i <= lat; i++) begin
      memread = 1'($urandom_range(0, 1)); memwrite = 1'($urandom_range(0, 1));
      IorD = 1'($urandom_range(0, 1)); IR_write = 1'($urandom_range(0, 1));
      pc = $urandom; alu_out = $urandom; write_data = $urandom;
      mem_ready = (i == lat);
      mem_rdata = (i == lat) ? rd : $urandom;
      #2;
      chk("busy_stall", stall, i != lat);
      chk("busy_addr", mem_addr, a);
      chk("busy_strobe", {mem_rd, mem_wr}, wr ? 2'b01 : 2'b10);
      if (stall) stall_cyc++;
      if (mem_rd | mem_wr) strobe_cyc++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic apply_reset();
    reset = 1;
    exp_instr = '0; exp_mdr = '0; exp_err = 0;
    sb_q.delete();
    memread = 1; memwrite = 0; IorD = 0; pc = 32'h100;
    @(posedge clk); #2;
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_strobe", {mem_rd, mem_wr}, 2'b00);
    chk("rst_instr", instr, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned s, st, n;
    logic [31:0] keep_instr, keep_mdr;
    reset = 1; idle_inputs();
    IorD = 0; IR_write = 0; pc = '0; alu_out = '0; write_data = '0; mem_rdata = '0;
    #1;
    apply_reset();

    // Fetch into IR, then back-to-back load into MDR.
    do_access(0, 0, 1, 32'h10, 32'h0, 32'h0, 32'h8C22_0004, 3, s, st);
    chk("fetch_stall_cycles", s, 4);
    #1;
    chk("fetch_instr", instr, 32'h8C22_0004);
    chk("fetch_opcode", opcode, 6'h23);
    do_access(0, 1, 0, 32'h0, 32'h100, 32'h0, 32'h1234, 0, s, st);
    chk("b2b_instr", instr, 32'h8C22_0004);
    chk("b2b_mdr", mdr, 32'h1234);

    // Store with immediate ready.
    keep_instr = instr; keep_mdr = mdr;
    do_access(1, 1, 0, 32'h8, 32'h40, 32'hDEAD_BEEF, $urandom, 0, s, st);
    chk("store_wr_cycles", st, 1);
    chk("store_instr", instr, keep_instr);
    chk("store_mdr", mdr, keep_mdr);
    idle_cycles(2);

    // Random legal traffic with random latency and gaps.
    for (int k = 0; k < 40; k++) begin
      int unsigned lat;
      lat = $urandom_range(0, TO - 1);
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                lat, s, st);
      chk("rand_stall_cycles", s, lat + 1);
      idle_cycles($urandom_range(0, 2));
    end

    // Timeout: read never answered.
    keep_mdr = mdr;
    memread = 1; memwrite = 0; IorD = 1; IR_write = 0; alu_out = 32'h80;
    #2;
    chk("to_issue_stall", stall, 1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      memread = 0;
      #2;
      if (!stall) break;
      n++;
    end
    chk("to_busy_stall_cycles", n, TO);
    chk("to_strobe_held", mem_rd, 1);
    @(posedge clk); #1;
    exp_err = 1;
    chk("to_err", err, 1);
    chk("to_strobe_clr", {mem_rd, mem_wr}, 2'b00);
    chk("to_mdr", mdr, keep_mdr);
    idle_cycles(2);
    apply_reset();

    // Illegal: both commands.
    memread = 1; memwrite = 1; IorD = 0; pc = 32'h20;
    #2;
    chk("both_stall", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    exp_err = 1;
    chk("both_err", err, 1);
    chk("both_strobe", {mem_rd, mem_wr}, 2'b00);
    idle_cycles(2);
    apply_reset();

    // Illegal: misaligned data address.
    memread = 1; memwrite = 0; IorD = 1; alu_out = 32'h42;
    #2;
    chk("misal_stall", stall, 0);
    @(posedge clk); #1;
    idle_inputs();
    exp_err = 1;
    chk("misal_err", err, 1);
    chk("misal_strobe", {mem_rd, mem_wr}, 2'b00);
    idle_cycles(2);
    apply_reset();

    // Reset asserted between edges while an access is outstanding.
    do_access(0, 0, 1, 32'h24, 32'h0, 32'h0, 32'hABCD_0000, 1, s, st);
    memread = 1; memwrite = 0; IorD = 0; pc = 32'h30;
    @(posedge clk); #2;
    chk("mid_strobe_pre", mem_rd, 1);
    chk("mid_stall_pre", stall, 1);
    reset = 1;
    exp_instr = '0; exp_mdr = '0; exp_err = 0;
    #1;
    chk("mid_strobe", {mem_rd, mem_wr}, 2'b00);
    chk("mid_stall", stall, 0);
    chk("mid_instr", instr, 0);
    chk("mid_addr", mem_addr, 0);
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;
    idle_cycles(2);
    do_access(0, 1, 0, 32'h0, 32'h44, 32'h0, 32'h5555_AAAA, 2, s, st);
    chk("post_rst_stall_cycles", s, 3);
    idle_cycles(2);

    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max wait cycles for mem_ready before an access is aborted.
REQ-002 SHALL have parameter AW, default 32, meaning address/data width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 memread  input  1  controller read request, sampled in IDLE.
REQ-006 memwrite  input  1  controller write request, sampled in IDLE.
REQ-007 IorD  input  1  address select: 0 = pc, 1 = alu_out.
REQ-008 IR_write  input  1  read destination: 1 = instruction register, 0 = MDR.
REQ-009 pc  input  AW  fetch address.
REQ-010 alu_out  input  AW  data address.
REQ-011 write_data  input  AW  store data.
REQ-012 mem_addr  output  AW  memory address, registered.
REQ-013 mem_rd / mem_wr  output  1 each  memory strobes, registered.
REQ-014 mem_wdata  output  AW  registered store data.
REQ-015 mem_rdata  input  AW  memory read data, valid with mem_ready.
REQ-016 mem_ready  input  1  memory completion, one cycle pulse or level.
REQ-017 stall  output  1  combinational; freezes controller state and PC while 1.
REQ-018 instr  output  AW  instruction register; opcode output = instr[31:26].
REQ-019 mdr  output  AW  memory data register.
REQ-020 err  output  1  sticky error flag.

Function
REQ-021 FSM SHALL have states IDLE, BUSY, with BUSY holding mem_addr/mem_rd/mem_wr/mem_wdata stable.
REQ-022 IDLE with exactly one of memread/memwrite = 1 and selected address[1:0] = 00: latch address (IorD ? alu_out : pc), write_data, command, IR_write; set strobe; go BUSY next edge.
REQ-023 stall = (IDLE and (memread or memwrite) and request legal) or (BUSY and not mem_ready and wait count < TIMEOUT).
REQ-024 BUSY with mem_ready = 1: read -> capture mem_rdata into instr (latched IR_write = 1) or mdr (= 0); write -> no register update; clear strobes; return IDLE same edge; stall = 0 that cycle.
REQ-025 Wait counter SHALL clear on entering BUSY, increment each BUSY cycle without mem_ready, saturate at TIMEOUT.
REQ-026 Count = TIMEOUT without mem_ready: set err, clear strobes, return IDLE, leave instr/mdr unchanged, stall = 0 that cycle.
REQ-027 memread and memwrite both 1 in IDLE: set err, no access, stall = 0.
REQ-028 Misaligned address (bits[1:0] != 00) in IDLE request: set err, no access, stall = 0.
REQ-029 Requests arriving while BUSY SHALL be ignored (controller is stalled).
REQ-030 mem_ready in IDLE SHALL be ignored.
REQ-031 err SHALL stay 1 until reset.
REQ-032 Minimum access latency: 2 cycles (issue cycle + ready cycle); back-to-back access from IDLE permitted the cycle after completion.

Reset
REQ-033 reset = 1 SHALL immediately force: state IDLE, mem_rd = mem_wr = 0, mem_addr = mem_wdata = 0, instr = 0, mdr = 0, err = 0, wait count = 0.
REQ-034 Reset mid-BUSY SHALL abort the access with no register update; stall = 0 while reset asserted.

Structure
REQ-035 Shared package SHALL hold the state enum (IDLE, BUSY), command enum (RD, WR), and default TIMEOUT constant.
REQ-036 Wait counter SHALL be a sub-module wait_timer (inputs clear, enable; output expired).

Verification
REQ-037 Fetch: memread = 1, IorD = 0, IR_write = 1, pc = 0x0000_0010, mem_ready after 3 cycles, rdata 0x8C22_0004 -> mem_addr 0x10, stall 1 for 4 cycles, instr = 0x8C22_0004, opcode = 0x23.
REQ-038 Store: memwrite = 1, IorD = 1, alu_out = 0x40, write_data = 0xDEAD_BEEF, immediate ready -> mem_wr 1 cycle, mem_wdata 0xDEADBEEF, mdr/instr unchanged.
REQ-039 Timeout: TIMEOUT = 4, read, mem_ready never -> err = 1 after 4 BUSY cycles, stall falls, mdr unchanged.
REQ-040 Illegal: memread = memwrite = 1 -> err = 1, no strobe; separately alu_out = 0x42 with IorD = 1 -> err = 1, no strobe.
REQ-041 Reset during BUSY: assert reset between edges -> strobes and stall 0 immediately, instr = 0, state IDLE.
REQ-042 Back-to-back: fetch completes, load to MDR issued next cycle with rdata 0x1234 -> instr retained, mdr = 0x1234.
